// File: rtl/mem_stage_pkg.sv
// Shared widths and load-type encodings for the memory-access stage.
// MEM_LOAD_EXT_EN widens the execute-stage bus with a 3-bit ld_type field.
package mem_stage_pkg;

`ifdef MEM_LOAD_EXT_EN
  localparam int ES_TO_MS_BUS_WD = 74;
`else
  localparam int ES_TO_MS_BUS_WD = 71;
`endif
  localparam int MS_TO_WS_BUS_WD = 70;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  // Common low 71 bits of the execute-stage bus.
  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: selects byte/halfword from the read word and extends it.
// Only instantiated when MEM_LOAD_EXT_EN is defined.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword misalignment is not checked; addr_lo[0] is ignored.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (ld_type_e'(ld_type))
      LD_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   load_value = {24'd0, byte_sel};
      LD_H:    load_value = {{16{half_sel[15]}}, half_sel};
      LD_HU:   load_value = {16'd0, half_sel};
      default: load_value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: merges SRAM read data with the ALU result and
// holds load data across write-back stalls. MEM_LOAD_EXT_EN enables lb/lbu/lh/lhu.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ws_allowin,
  output logic                        ms_allowin,
  input  logic                        es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus,
  output logic                        ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0]  ms_to_ws_bus,
  input  logic [31:0]                 data_sram_rdata,
  output logic                        ms_load_op,
  output logic [4:0]                  ms_dest,
  output logic [31:0]                 ms_to_ds_result
);

  logic        ms_valid;
  logic        ms_first;
  es_bus_t     bus_r;
  logic [31:0] rdata_buf;
  logic        rdata_buf_vld;
  logic [31:0] rdata_src;
  logic [31:0] load_value;
  logic [31:0] final_result;
  logic        capture;
  logic        handoff;
  logic        hold;

  assign ms_allowin     = !ms_valid || ws_allowin;
  assign ms_to_ws_valid = ms_valid;
  assign capture        = es_to_ms_valid && ms_allowin;
  assign handoff        = ms_valid && ws_allowin;
  // SRAM data is only valid in the first cycle; capture it if WB is stalling.
  assign hold           = ms_valid && ms_first && bus_r.res_from_mem && !ws_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid      <= 1'b0;
      ms_first      <= 1'b0;
      bus_r         <= '0;
      rdata_buf     <= '0;
      rdata_buf_vld <= 1'b0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      ms_first <= capture;
      if (capture) bus_r <= es_bus_t'(es_to_ms_bus[70:0]);
      // Clear has priority so a stale buffer never reaches the next instruction.
      if (handoff) begin
        rdata_buf_vld <= 1'b0;
      end else if (hold) begin
        rdata_buf     <= data_sram_rdata;
        rdata_buf_vld <= 1'b1;
      end
    end
  end

  assign rdata_src = rdata_buf_vld ? rdata_buf : data_sram_rdata;

`ifdef MEM_LOAD_EXT_EN
  logic [2:0] ld_type_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      ld_type_r <= 3'd0;
    else if (capture) ld_type_r <= es_to_ms_bus[73:71];
  end

  load_align u_load_align (
    .ld_type    (ld_type_r),
    .addr_lo    (bus_r.alu_result[1:0]),
    .rdata      (rdata_src),
    .load_value (load_value)
  );
`else
  assign load_value = rdata_src;
`endif

  assign final_result    = bus_r.res_from_mem ? load_value : bus_r.alu_result;
  assign ms_to_ws_bus    = {bus_r.gr_we, bus_r.dest, final_result, bus_r.pc};
  assign ms_to_ds_result = final_result;
  assign ms_load_op      = ms_valid && bus_r.res_from_mem;
  assign ms_dest         = (ms_valid && bus_r.gr_we) ? bus_r.dest : 5'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB bus queued at issue, checked
// every cycle the stage holds an instruction and popped on handoff.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       resetn = 1'b0;
  logic                       ws_allowin = 1'b0;
  logic                       ms_allowin;
  logic                       es_to_ms_valid = 1'b0;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus = '0;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [31:0]                data_sram_rdata = '0;
  logic                       ms_load_op;
  logic [4:0]                 ms_dest;
  logic [31:0]                ms_to_ds_result;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_load_op      (ms_load_op),
    .ms_dest         (ms_dest),
    .ms_to_ds_result (ms_to_ds_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [69:0] bus;
    logic        load;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [73:0] mk(input logic [2:0] ld, input logic rfm, input logic we,
                                     input logic [4:0] d, input logic [31:0] alu, input logic [31:0] pc);
    mk = {ld, rfm, we, d, alu, pc};
  endfunction

  task automatic issue(input logic [2:0] ld, input logic rfm, input logic we, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] fin);
    exp_t e;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = ES_TO_MS_BUS_WD'(mk(ld, rfm, we, d, alu, pc));
    e.bus  = {we, d, fin, pc};
    e.load = rfm;
    sb.push_back(e);
  endtask

  // Load that sees its read data in the cycle after capture, then garbage.
  task automatic run_load(input logic [2:0] ld, input logic [4:0] d, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [31:0] fin);
    issue(ld, 1'b1, 1'b1, d, addr, 32'hBFC0_0000 + addr, fin);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = rd;
    step();
    data_sram_rdata = 32'hFFFF_FFFF;
  endtask

  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 70'(ms_to_ws_valid), 70'(0));
      end else begin
        chk("ws_bus", ms_to_ws_bus, sb[0].bus);
        chk("ds_result", 70'(ms_to_ds_result), 70'(sb[0].bus[63:32]));
        chk("ms_dest", 70'(ms_dest), 70'(sb[0].bus[69] ? sb[0].bus[68:64] : 5'd0));
        chk("load_op", 70'(ms_load_op), 70'(sb[0].load));
        chk("allowin", 70'(ms_allowin), 70'(ws_allowin));
        if (ws_allowin) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2;
    chk("rst_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("rst_allowin", 70'(ms_allowin), 70'(1));
    chk("rst_bus", ms_to_ws_bus, 70'(0));
    chk("rst_dest", 70'(ms_dest), 70'(0));
    chk("rst_ds_result", 70'(ms_to_ds_result), 70'(0));
    chk("rst_load_op", 70'(ms_load_op), 70'(0));
    #10 resetn = 1'b1;
    step();

    // lw, no stall
    ws_allowin = 1'b1;
    run_load(3'd0, 5'd3, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // lw held across a 3-cycle write-back stall
    ws_allowin = 1'b0;
    issue(3'd0, 1'b1, 1'b1, 5'd7, 32'h104, 32'hBFC0_0104, 32'h1234_5678);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h1234_5678;
    step();
    data_sram_rdata = 32'hFFFF_FFFF;
    step();
    step();
    ws_allowin = 1'b1;
    step();
    chk("buf_cleared", 70'(dut.rdata_buf_vld), 70'(0));

    // ALU result passes through
    issue(3'd0, 1'b0, 1'b1, 5'd9, 32'h0000_002A, 32'hBFC0_0108, 32'h0000_002A);
    step();
    es_to_ms_valid = 1'b0;
    step();

    // Stalled load released while the next load is captured
    ws_allowin = 1'b0;
    issue(3'd0, 1'b1, 1'b1, 5'd10, 32'h200, 32'hBFC0_0200, 32'h1111_1111);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h1111_1111;
    step();
    data_sram_rdata = 32'hFFFF_FFFF;
    ws_allowin = 1'b1;
    issue(3'd0, 1'b1, 1'b1, 5'd11, 32'h204, 32'hBFC0_0204, 32'h2222_2222);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h2222_2222;
    step();
    data_sram_rdata = 32'hFFFF_FFFF;

    // Non-writing load: bypass dest must read 0
    issue(3'd0, 1'b1, 1'b0, 5'd15, 32'h208, 32'hBFC0_0208, 32'h5555_AAAA);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h5555_AAAA;
    step();
    data_sram_rdata = 32'hFFFF_FFFF;

`ifdef MEM_LOAD_EXT_EN
    run_load(3'd1, 5'd20, 32'h301, 32'h80FF_7F01, 32'h0000_007F);
    run_load(3'd1, 5'd21, 32'h303, 32'h80FF_7F01, 32'hFFFF_FF80);
    run_load(3'd2, 5'd22, 32'h302, 32'h80FF_7F01, 32'h0000_00FF);
    run_load(3'd3, 5'd23, 32'h302, 32'h80FF_7F01, 32'hFFFF_80FF);
    run_load(3'd4, 5'd24, 32'h300, 32'h80FF_7F01, 32'h0000_7F01);
`endif

    // Reset in the middle of a stall
    ws_allowin = 1'b0;
    issue(3'd0, 1'b1, 1'b1, 5'd12, 32'h400, 32'hBFC0_0400, 32'h3333_3333);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h3333_3333;
    step();
    data_sram_rdata = 32'hFFFF_FFFF;
    #2 resetn = 1'b0;
    #1;
    chk("midrst_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("midrst_allowin", 70'(ms_allowin), 70'(1));
    chk("midrst_dest", 70'(ms_dest), 70'(0));
    sb.delete();
    step();
    resetn = 1'b1;
    ws_allowin = 1'b1;
    run_load(3'd0, 5'd13, 32'h404, 32'h4444_4444, 32'h4444_4444);
    step();

    chk("drain", 70'(sb.size()), 70'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
